// File: rtl/cm_sync_sink.sv
// Clocked sink for a 2-phase bundled-data channel: synchronises the request,
// stores payload plus source tag in a small FIFO and returns a toggle acknowledge.
module cm_sync_sink #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     MR_n,
    input  logic                     Send_in,
    input  logic [DATA_W-1:0]        Data_in,
    input  logic                     Src_in,
    output logic                     Ack_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_src,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

    logic              s1_r;
    logic              s2_r;
    logic              phase_r;
    logic              ack_r;
    logic              valid_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [OCC_W-1:0]  occ_r;
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic              src_mem_r  [DEPTH];

    logic              pending_s;
    logic              push_s;
    logic              pop_s;
    logic [OCC_W-1:0]  occ_next_s;

    // Push/pop decisions; a full FIFO refuses a push even when a pop is in flight.
    always_comb begin
        pending_s  = (s2_r != phase_r);
        push_s     = pending_s && (occ_r != FULL_LVL);
        pop_s      = valid_r && out_ready;
        occ_next_s = occ_r;
        if (push_s && !pop_s) begin
            occ_next_s = occ_r + OCC_W'(1'b1);
        end else if (pop_s && !push_s) begin
            occ_next_s = occ_r - OCC_W'(1'b1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Synchroniser, handshake phase, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            phase_r  <= 1'b0;
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            s1_r    <= Send_in;
            s2_r    <= s1_r;
            occ_r   <= occ_next_s;
            valid_r <= (occ_next_s != '0);
            if (push_s) begin
                phase_r  <= s2_r;
                ack_r    <= ~ack_r;
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
        end
    end

    // Storage array; contents are don't-care after reset so it carries none.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= Data_in;
            src_mem_r[wr_ptr_r]  <= Src_in;
        end
    end

    assign Ack_out   = ack_r;
    assign out_valid = valid_r;
    assign occupancy = occ_r;
    assign out_data  = data_mem_r[rd_ptr_r];
    assign out_src   = src_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_cm_sync_sink.sv
// Directed bench for cm_sync_sink: stimulus queues expected packets,
// a negedge monitor pops and compares every accepted output transfer.
module tb_cm_sync_sink;

    logic        clk;
    logic        mr_n;
    logic        send_in;
    logic [15:0] data_in;
    logic        src_in;
    logic        ack_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_src;
    logic [2:0]  occupancy;

    int          total = 0;
    int          bad   = 0;
    logic [16:0] exp_q [$];
    logic        send_lvl = 1'b0;
    logic        exp_ack  = 1'b0;
    logic [15:0] ready_pat = 16'b1011_0110_1101_0011;
    int          pidx = 0;
    bit          rr_en = 1'b0;

    cm_sync_sink #(.DATA_W(16), .DEPTH(4)) dut (
        .CLK       (clk),
        .MR_n      (mr_n),
        .Send_in   (send_in),
        .Data_in   (data_in),
        .Src_in    (src_in),
        .Ack_out   (ack_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_en) begin
            out_ready = ready_pat[pidx % 16];
            pidx++;
        end
    endtask

    task automatic send_pkt(input logic [15:0] d, input logic s);
        data_in  = d;
        src_in   = s;
        send_lvl = ~send_lvl;
        send_in  = send_lvl;
        exp_q.push_back({s, d});
    endtask

    task automatic wait_ack(input string nm);
        exp_ack = ~exp_ack;
        for (int n = 0; n < 16; n++) begin
            if (ack_out === exp_ack) break;
            tick();
        end
        chk(nm, {31'd0, ack_out}, {31'd0, exp_ack});
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (occupancy == 3'd0) break;
            tick();
        end
        chk(nm, {29'd0, occupancy}, 32'd0);
    endtask

    // Scoreboard monitor: a transfer happens at the next edge when valid && ready.
    always @(negedge clk) begin
        if (mr_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stale_pop: got %h/%h expected no packet", out_src, out_data);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("pop_pkt", {15'd0, out_src, out_data}, {15'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mr_n = 1'b0; send_in = 1'b0; data_in = 16'h0000; src_in = 1'b0; out_ready = 1'b0;

        // Reset with Send_in toggling
        tick(); send_in = 1'b1;
        tick(); send_in = 1'b0;
        tick();
        chk("rst_ack",   {31'd0, ack_out},   32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ",   {29'd0, occupancy}, 32'd0);
        send_lvl = 1'b0; mr_n = 1'b1;
        repeat (5) tick();
        chk("idle_occ", {29'd0, occupancy}, 32'd0);
        chk("idle_ack", {31'd0, ack_out},   32'd0);

        // Single packet, latency of 3 edges
        out_ready = 1'b1;
        send_pkt(16'hA5A5, 1'b1);
        tick(); tick();
        chk("lat_no_ack_e1", {31'd0, ack_out}, 32'd0);
        tick();
        chk("lat_ack_e2",   {31'd0, ack_out},   32'd1);
        chk("lat_valid_e2", {31'd0, out_valid}, 32'd1);
        chk("lat_occ_e2",   {29'd0, occupancy}, 32'd1);
        exp_ack = 1'b1;
        tick();
        chk("single_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("single_occ_zero",   {29'd0, occupancy}, 32'd0);

        // Fill and stall, fifth packet held
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_pkt(16'(i), 1'b0);
            wait_ack("fill_ack");
        end
        tick();
        chk("fill_occ4", {29'd0, occupancy}, 32'd4);
        send_pkt(16'd5, 1'b1);
        repeat (6) tick();
        chk("full_no_ack", {31'd0, ack_out},   {31'd0, exp_ack});
        chk("full_occ4",   {29'd0, occupancy}, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("pop_no_push_ack", {31'd0, ack_out},   {31'd0, exp_ack});
        chk("pop_no_push_occ", {29'd0, occupancy}, 32'd3);
        tick();
        exp_ack = ~exp_ack;
        chk("late_push_ack", {31'd0, ack_out}, {31'd0, exp_ack});
        drain("fill_drain");

        // Full with a one-cycle pop pulse
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pkt(16'h0011 + 16'(i), 1'(i));
            wait_ack("full2_ack");
        end
        send_pkt(16'h0015, 1'b0);
        repeat (4) tick();
        chk("full2_occ4", {29'd0, occupancy}, 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pulse_occ3",   {29'd0, occupancy}, 32'd3);
        chk("pulse_no_ack", {31'd0, ack_out},   {31'd0, exp_ack});
        tick();
        exp_ack = ~exp_ack;
        chk("pulse_occ4", {29'd0, occupancy}, 32'd4);
        chk("pulse_ack",  {31'd0, ack_out},   {31'd0, exp_ack});
        drain("full2_drain");

        // Wrap-around stream with a patterned consumer
        rr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_pkt(16'h1000 + 16'(i * 16'h0111), 1'(i % 2));
            wait_ack("wrap_ack");
        end
        rr_en = 1'b0;
        drain("wrap_drain");

        // Reset mid-operation with a pending request
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_pkt(16'hBEE0 + 16'(i), 1'b1);
            wait_ack("pre_rst_ack");
        end
        send_pkt(16'hDEAD, 1'b0);
        tick();
        chk("pre_rst_occ3", {29'd0, occupancy}, 32'd3);
        mr_n = 1'b0; send_in = 1'b0; send_lvl = 1'b0;
        tick();
        exp_q.delete();
        exp_ack = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_occ",   {29'd0, occupancy}, 32'd0);
        chk("mid_rst_ack",   {31'd0, ack_out},   32'd0);
        mr_n = 1'b1; out_ready = 1'b1;
        repeat (8) tick();
        chk("post_rst_occ",   {29'd0, occupancy}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
